mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: BASE_ADDR, default 32'h0100_0000, first valid byte address; MEM_DEPTH, default 1024, memory size in 32-bit words; MAX_DATA_RUN, default 4, max consecutive data grants while fetch waits.
REQ-002 SHALL have ports: clock, in, 1, sole clock (rising edge); reset, in, 1, synchronous, active-high.
REQ-003 SHALL have ports: f_req, in, 1, fetch request; f_addr, in, 32, fetch byte address; f_gnt, out, 1, fetch accepted; f_rvalid, out, 1, fetch response; f_rdata, out, 32, instruction word; f_err, out, 1, fetch fault (qualified by f_rvalid).
REQ-004 SHALL have ports: d_req, in, 1, data request; d_we, in, 1, store; d_size, in, 2, 00 byte, 01 half, 10 word; d_addr, in, 32; d_wdata, in, 32, data in low bits; d_gnt, out, 1; d_rvalid, out, 1; d_rdata, out, 32, raw word; d_err, out, 1.
REQ-005 SHALL have ports: mem_req, out, 1; mem_we, out, 1; mem_addr, out, 32, word-aligned; mem_wdata, out, 32; mem_be, out, 4, byte enables; mem_rvalid, in, 1, completion (reads and writes, latency >= 1); mem_rdata, in, 32.

Function
REQ-006 SHALL implement FSM states IDLE, BUSY_F, BUSY_D, ERR_RSP, with at most one outstanding access.
REQ-007 In IDLE, arbitration SHALL be combinational: a grant pulses f_gnt or d_gnt for one cycle, in the same cycle as the winning request.
REQ-008 Arbitration SHALL give data priority, except fetch wins when run_cnt == MAX_DATA_RUN and f_req is high.
REQ-009 run_cnt SHALL increment on each d grant while f_req is high, saturate at MAX_DATA_RUN, and clear on any f grant.
REQ-010 A legal grant SHALL drive mem_req, mem_we, mem_addr = {addr[31:2], 2'b00}, mem_be and mem_wdata in the same cycle, and then enter BUSY_F or BUSY_D.
REQ-011 mem_be SHALL be: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << {addr[1], 1'b0}; word = 4'b1111.
REQ-012 mem_wdata SHALL replicate the byte or half into all lanes; fetch is always a word read with we = 0.
REQ-013 mem_req SHALL be high only in the grant cycle.
REQ-014 In BUSY_x, mem_rvalid SHALL produce x_rvalid = 1 and x_rdata = mem_rdata in the same cycle, then return to IDLE; the earliest new grant is the next cycle.
REQ-015 An illegal request SHALL be granted with no mem_req, enter ERR_RSP, and in the next cycle assert x_rvalid and x_err with x_rdata = 0.
REQ-016 Illegal means: address < BASE_ADDR; or address >= BASE_ADDR + 4*MEM_DEPTH; or misaligned (half with addr[0] set; word or fetch with addr[1:0] != 0); or d_size = 11.
REQ-017 The address-range compare SHALL be done in 33 bits so that the limit does not wrap.
REQ-018 No grant SHALL occur outside IDLE; requesters hold req and payload until gnt.
REQ-019 mem_rvalid in IDLE or ERR_RSP SHALL be ignored.
REQ-020 x_rvalid SHALL be a one-cycle pulse, and x_err SHALL be 0 whenever x_rvalid = 0.

Reset
REQ-021 When reset is high at a clock edge: state = IDLE, run_cnt = 0, all outputs 0.
REQ-022 Reset mid-access SHALL abandon the access, with no response pulse to the requester.
REQ-023 A late mem_rvalid after reset SHALL be dropped per REQ-019.

Structure
REQ-024 Package mem_arb_pkg SHALL hold: the state enum; size encodings SZ_BYTE, SZ_HALF, SZ_WORD; and the BASE_ADDR default.
REQ-025 Sub-module mem_lane_fmt SHALL be purely combinational and compute mem_be, mem_wdata and the misalign flag; the FSM and arbitration stay in the top module.

Verification
REQ-026 Case 1: f_req, f_addr = 32'h0100_0000, mem_rvalid 2 cycles later with rdata = 32'h0000_0093 -> f_gnt in cycle 0, mem_be = 4'hF, f_rvalid and f_rdata = 32'h93 in cycle 2.
REQ-027 Case 2: f_req and d_req both held high for 6 transactions (mem latency 1) -> grant order D, D, D, D, F, D.
REQ-028 Case 3: d store byte, d_addr = 32'h0100_0007, d_wdata = 32'h0000_00AB -> mem_addr = 32'h0100_0004, mem_be = 4'b1000, mem_wdata = 32'hABAB_ABAB.
REQ-029 Case 4: d word load at 32'h0100_0002, then fetch at 32'h0000_0000 -> each granted, no mem_req, err response in the next cycle, FSM back in IDLE.
REQ-030 Case 5: reset asserted in BUSY_D, then mem_rvalid pulsed in the cycle after reset deasserts -> no d_rvalid, and a subsequent fetch is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, access sizes and default memory window for mem_port_arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D, ERR_RSP} state_e;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h0100_0000;
endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: byte enables, lane-replicated write data and misalignment flag for one access.
module mem_lane_fmt
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);
  always_comb begin
    be_o = size_i == SZ_BYTE ? 4'b0001 << addr_i :
           size_i == SZ_HALF ? 4'b0011 << {addr_i[1], 1'b0} :
           size_i == SZ_WORD ? 4'b1111 : 4'b0000;
    wdata_o = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
              size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    misalign_o = (size_i == SZ_HALF && addr_i[0]) || (size_i == SZ_WORD && addr_i != 2'b00);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch and data ports onto one memory port, one access outstanding.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEF,
  parameter int          MEM_DEPTH    = 1024,
  parameter int          MAX_DATA_RUN = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int RW = $clog2(MAX_DATA_RUN + 2);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DATA_RUN);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(MEM_DEPTH) << 2);
  state_e state_q, state_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic err_f_q, err_f_d;
  logic live, f_win, d_win, legal, misalign;
  logic [31:0] sel_addr, fmt_wdata;
  logic [1:0] sel_size;
  logic [3:0] fmt_be;
  assign live = !reset;
  assign f_win = live && state_q == IDLE && f_req && (!d_req || run_cnt_q == RUN_MAX);
  assign d_win = live && state_q == IDLE && d_req && !f_win;
  assign sel_addr = f_win ? f_addr : d_addr;
  assign sel_size = f_win ? SZ_WORD : d_size;
  mem_lane_fmt u_fmt (
    .size_i    (sel_size),
    .addr_i    (sel_addr[1:0]),
    .wdata_i   (f_win ? 32'h0 : d_wdata),
    .be_o      (fmt_be),
    .wdata_o   (fmt_wdata),
    .misalign_o(misalign)
  );
  // 33-bit compare keeps BASE_ADDR + 4*MEM_DEPTH from wrapping near the top of the space
  assign legal = {1'b0, sel_addr} >= {1'b0, BASE_ADDR} && {1'b0, sel_addr} < LIMIT &&
                 !misalign && sel_size != 2'b11;
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    err_f_d   = err_f_q;
    f_gnt     = f_win;
    d_gnt     = d_win;
    mem_req   = (f_win || d_win) && legal;
    mem_we    = mem_req && d_win && d_we;
    mem_addr  = mem_req ? {sel_addr[31:2], 2'b00} : 32'h0;
    mem_be    = mem_req ? fmt_be : 4'h0;
    mem_wdata = mem_req ? fmt_wdata : 32'h0;
    f_err     = live && state_q == ERR_RSP && err_f_q;
    d_err     = live && state_q == ERR_RSP && !err_f_q;
    f_rvalid  = f_err || (live && state_q == BUSY_F && mem_rvalid);
    d_rvalid  = d_err || (live && state_q == BUSY_D && mem_rvalid);
    f_rdata   = live && state_q == BUSY_F && mem_rvalid ? mem_rdata : 32'h0;
    d_rdata   = live && state_q == BUSY_D && mem_rvalid ? mem_rdata : 32'h0;
    if (f_win || d_win) begin
      state_d   = !legal ? ERR_RSP : f_win ? BUSY_F : BUSY_D;
      err_f_d   = f_win;
      run_cnt_d = f_win ? '0 : (f_req && run_cnt_q != RUN_MAX) ? RW'(run_cnt_q + 1'b1) : run_cnt_q;
    end else if (((state_q == BUSY_F || state_q == BUSY_D) && mem_rvalid) || state_q == ERR_RSP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      run_cnt_q <= '0;
      err_f_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      err_f_q   <= err_f_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic clock = 1'b0;
  logic reset;
  logic f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [1:0] d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic mem_req, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  int tests = 0;
  int fails = 0;
  always #5 clock = ~clock;
  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic d_ok(input logic we, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd);
    d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wd;
    #1;
    chk("d_ok gnt", d_gnt, 1);
    chk("d_ok mem_req", mem_req, 1);
    chk("d_ok mem_we", mem_we, we);
    chk("d_ok mem_addr", mem_addr, e_addr);
    chk("d_ok mem_be", mem_be, e_be);
    if (we) chk("d_ok mem_wdata", mem_wdata, e_wd);
    @(negedge clock);
    d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
    #1;
    chk("d_ok rvalid", d_rvalid, 1);
    chk("d_ok err", d_err, 0);
    chk("d_ok rdata", d_rdata, 32'hCAFE_0001);
    @(negedge clock);
    mem_rvalid = 1'b0;
  endtask
  task automatic d_bad(input logic [1:0] size, input logic [31:0] addr);
    d_req = 1'b1; d_we = 1'b0; d_size = size; d_addr = addr;
    #1;
    chk("d_bad gnt", d_gnt, 1);
    chk("d_bad no mem_req", mem_req, 0);
    @(negedge clock);
    d_req = 1'b0;
    #1;
    chk("d_bad rvalid", d_rvalid, 1);
    chk("d_bad err", d_err, 1);
    chk("d_bad rdata", d_rdata, 0);
    @(negedge clock);
    #1;
    chk("d_bad rvalid pulse", d_rvalid, 0);
    chk("d_bad err low", d_err, 0);
  endtask
  initial begin
    logic [7:0] order [6];
    logic [7:0] g;
    order = '{"D", "D", "D", "D", "F", "D"};
    reset = 1'b1; f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_size = 2'b10; d_addr = 0; d_wdata = 0;
    mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset mem_req", mem_req, 0);
    chk("reset f_rvalid", f_rvalid, 0);
    chk("reset d_rvalid", d_rvalid, 0);
    @(negedge clock);
    reset = 1'b0;
    // Case 1: fetch with latency 2, data held off while busy
    @(negedge clock);
    f_req = 1; f_addr = 32'h0100_0000;
    #1;
    chk("c1 f_gnt", f_gnt, 1);
    chk("c1 d_gnt", d_gnt, 0);
    chk("c1 mem_req", mem_req, 1);
    chk("c1 mem_we", mem_we, 0);
    chk("c1 mem_addr", mem_addr, 32'h0100_0000);
    chk("c1 mem_be", mem_be, 4'hF);
    @(negedge clock);
    f_req = 0; d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h0100_0008;
    #1;
    chk("c1 busy no d_gnt", d_gnt, 0);
    chk("c1 busy no mem_req", mem_req, 0);
    chk("c1 no early f_rvalid", f_rvalid, 0);
    @(negedge clock);
    mem_rvalid = 1; mem_rdata = 32'h0000_0093;
    #1;
    chk("c1 f_rvalid", f_rvalid, 1);
    chk("c1 f_rdata", f_rdata, 32'h93);
    chk("c1 f_err", f_err, 0);
    chk("c1 no gnt in rsp cycle", d_gnt, 0);
    @(negedge clock);
    mem_rvalid = 0;
    #1;
    chk("c1 f_rvalid pulse", f_rvalid, 0);
    chk("c1 d_gnt next", d_gnt, 1);
    chk("c1 d mem_addr", mem_addr, 32'h0100_0008);
    @(negedge clock);
    d_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0055;
    #1;
    chk("c1 d_rvalid", d_rvalid, 1);
    chk("c1 d_rdata", d_rdata, 32'h55);
    @(negedge clock);
    mem_rvalid = 0;
    // Case 2: both requesters held, data run limited to 4
    f_req = 1; f_addr = 32'h0100_0010; d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h0100_0020;
    for (int i = 0; i < 6; i++) begin
      #1;
      g = d_gnt ? "D" : f_gnt ? "F" : "-";
      chk($sformatf("c2 grant %0d", i), {24'h0, g}, {24'h0, order[i]});
      @(negedge clock);
      mem_rvalid = 1; mem_rdata = 32'(i);
      #1;
      chk($sformatf("c2 rvalid %0d", i), order[i] == "D" ? d_rvalid : f_rvalid, 1);
      @(negedge clock);
      mem_rvalid = 0;
    end
    f_req = 0; d_req = 0;
    // Case 3: lane formatting and range edges
    @(negedge clock);
    d_ok(1'b1, 2'b00, 32'h0100_0007, 32'h0000_00AB, 32'h0100_0004, 4'b1000, 32'hABAB_ABAB);
    d_ok(1'b1, 2'b01, 32'h0100_0102, 32'h0000_1234, 32'h0100_0100, 4'b1100, 32'h1234_1234);
    d_ok(1'b1, 2'b00, 32'h0100_0FFD, 32'h0000_005A, 32'h0100_0FFC, 4'b0010, 32'h5A5A_5A5A);
    d_ok(1'b0, 2'b10, 32'h0100_0FFC, 32'h0, 32'h0100_0FFC, 4'b1111, 32'h0);
    // Case 4: illegal requests
    d_bad(2'b10, 32'h0100_0002);
    d_bad(2'b10, 32'h0100_1000);
    d_bad(2'b01, 32'h0100_0001);
    d_bad(2'b11, 32'h0100_0000);
    d_bad(2'b00, 32'hFFFF_FFFF);
    f_req = 1; f_addr = 32'h0000_0000;
    #1;
    chk("c4 f_gnt", f_gnt, 1);
    chk("c4 f no mem_req", mem_req, 0);
    @(negedge clock);
    f_req = 0;
    #1;
    chk("c4 f_rvalid", f_rvalid, 1);
    chk("c4 f_err", f_err, 1);
    chk("c4 f_rdata", f_rdata, 0);
    chk("c4 d_rvalid quiet", d_rvalid, 0);
    @(negedge clock);
    d_ok(1'b0, 2'b10, 32'h0100_0040, 32'h0, 32'h0100_0040, 4'b1111, 32'h0);
    // Case 5: reset abandons a data access, late completion dropped
    d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h0100_0010;
    #1;
    chk("c5 d_gnt", d_gnt, 1);
    @(negedge clock);
    d_req = 0; reset = 1;
    #1;
    chk("c5 rst mem_req", mem_req, 0);
    @(negedge clock);
    reset = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("c5 late d_rvalid", d_rvalid, 0);
    chk("c5 late f_rvalid", f_rvalid, 0);
    @(negedge clock);
    mem_rvalid = 0; f_req = 1; f_addr = 32'h0100_0FFC;
    #1;
    chk("c5 f_gnt", f_gnt, 1);
    chk("c5 mem_req", mem_req, 1);
    chk("c5 mem_addr", mem_addr, 32'h0100_0FFC);
    @(negedge clock);
    f_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    #1;
    chk("c5 f_rvalid", f_rvalid, 1);
    chk("c5 f_rdata", f_rdata, 32'h13);
    chk("c5 d_rvalid quiet", d_rvalid, 0);
    @(negedge clock);
    mem_rvalid = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
